phase1_control_unit: RTL and testbench

- Moore-style control sequencer for the phase-1 bus datapath (register file R0–R15, Y, Z, HI/LO, PC, MAR, MDR, IR, ALU).
- Drives every datapath strobe to run fetch (T0–T2) and execute (T3–T6) for register-format ALU, mul and div instructions.
- Replaces the hand-written per-state strobe sequences in the phase-1 testbenches.
- Reads the datapath IR output; loops fetch/execute while Run is held.

---
 rtl/phase1_control_unit.sv | 149 ++++++++++++++
 tb/tb_phase1_control_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/phase1_control_unit.sv
// rtl/phase1_control_unit.sv - fetch/execute strobe sequencer for the phase-1 bus datapath
module phase1_control_unit #(
    parameter int         NUM_REGS = 16,
    parameter logic [4:0] OPC_MUL  = 5'b01111,
    parameter logic [4:0] OPC_DIV  = 5'b10000
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Run,
    input  logic [31:0]         IR,
    output logic                PCout,
    output logic                ZHIout,
    output logic                ZLOout,
    output logic                MDRout,
    output logic                PCin,
    output logic                IncrementPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                HIin,
    output logic                LOin,
    output logic                Read,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [4:0]          ALUControl,
    output logic                Done,
    output logic                Illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t     state;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_muldiv, is_unary, is_legal;
    logic       unused_ir_bits;

    assign opcode         = IR[31:27];
    assign ra             = IR[26:23];
    assign rb             = IR[22:19];
    assign rc             = IR[18:15];
    assign unused_ir_bits = ^IR[14:0];

    // Decode always looks at the live IR; it is only meaningful from T3 onward.
    assign is_muldiv = (opcode == OPC_MUL) || (opcode == OPC_DIV);
    assign is_unary  = (opcode == 5'b10001) || (opcode == 5'b10010);
    assign is_legal  = is_muldiv || is_unary || (opcode inside {[5'b00011:5'b01011]});

    function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (Run) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   state <= S_T2;
                S_T2:   state <= S_T3;
                S_T3:   state <= is_legal ? S_T4 : S_HALT;
                S_T4:   state <= S_T5;
                S_T5: begin
                    if (is_muldiv) state <= S_T6;
                    else           state <= Run ? S_T0 : S_IDLE;
                end
                S_T6:   state <= Run ? S_T0 : S_IDLE;
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        PCout       = 1'b0;
        ZHIout      = 1'b0;
        ZLOout      = 1'b0;
        MDRout      = 1'b0;
        PCin        = 1'b0;
        IncrementPC = 1'b0;
        MARin       = 1'b0;
        MDRin       = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        HIin        = 1'b0;
        LOin        = 1'b0;
        Read        = 1'b0;
        Rin         = '0;
        Rout        = '0;
        ALUControl  = 5'd0;
        Done        = 1'b0;
        Illegal     = (state == S_HALT);
        case (state)
            S_T0: begin
                PCout       = 1'b1;
                MARin       = 1'b1;
                IncrementPC = 1'b1;
                Zin         = 1'b1;
            end
            S_T1: begin
                ZLOout = 1'b1;
                PCin   = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (is_legal) begin
                    Yin  = 1'b1;
                    Rout = onehot(is_muldiv ? ra : rb);
                end
            end
            S_T4: begin
                // neg/not take their operand from Rb; the ALU ignores Y for them.
                Zin        = 1'b1;
                ALUControl = opcode;
                Rout       = onehot((is_muldiv || is_unary) ? rb : rc);
            end
            S_T5: begin
                ZLOout = 1'b1;
                if (is_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    Rin  = onehot(ra);
                    Done = 1'b1;
                end
            end
            S_T6: begin
                ZHIout = 1'b1;
                HIin   = 1'b1;
                Done   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_phase1_control_unit.sv
// tb/tb_phase1_control_unit.sv - randomized bench with an instruction-level strobe model
module tb_phase1_control_unit;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Run = 1'b0;
    logic [31:0] IR = 32'd0;
    logic        PCout, ZHIout, ZLOout, MDRout, PCin, IncrementPC, MARin, MDRin, IRin;
    logic        Yin, Zin, HIin, LOin, Read, Done, Illegal;
    logic [15:0] Rin, Rout;
    logic [4:0]  ALUControl;

    phase1_control_unit #(.NUM_REGS(16)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR),
        .PCout(PCout), .ZHIout(ZHIout), .ZLOout(ZLOout), .MDRout(MDRout),
        .PCin(PCin), .IncrementPC(IncrementPC), .MARin(MARin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .Read(Read),
        .Rin(Rin), .Rout(Rout), .ALUControl(ALUControl), .Done(Done), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    localparam logic [52:0] F_PCOUT  = 53'h1 << 0;
    localparam logic [52:0] F_ZHIOUT = 53'h1 << 1;
    localparam logic [52:0] F_ZLOOUT = 53'h1 << 2;
    localparam logic [52:0] F_MDROUT = 53'h1 << 3;
    localparam logic [52:0] F_PCIN   = 53'h1 << 4;
    localparam logic [52:0] F_INCPC  = 53'h1 << 5;
    localparam logic [52:0] F_MARIN  = 53'h1 << 6;
    localparam logic [52:0] F_MDRIN  = 53'h1 << 7;
    localparam logic [52:0] F_IRIN   = 53'h1 << 8;
    localparam logic [52:0] F_YIN    = 53'h1 << 9;
    localparam logic [52:0] F_ZIN    = 53'h1 << 10;
    localparam logic [52:0] F_HIIN   = 53'h1 << 11;
    localparam logic [52:0] F_LOIN   = 53'h1 << 12;
    localparam logic [52:0] F_READ   = 53'h1 << 13;
    localparam logic [52:0] F_DONE   = 53'h1 << 14;
    localparam logic [52:0] F_ILL    = 53'h1 << 15;

    typedef struct {
        logic [52:0] v;
        bit          drive_ir;
        bit          last;
        bit          halt;
    } step_t;

    typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;

    step_t       q[$];
    mode_t       mode = M_IDLE;
    logic [31:0] cur_ir, pending_ir;
    bit          rst_s = 1'b0, run_s = 1'b0;
    int          total = 0, bad = 0, cyc = 0, t0_cyc = 0;
    logic [52:0] act, expv;
    logic [4:0]  legal_ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                    5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10001,
                                    5'b10010, 5'b01111, 5'b10000};

    function automatic logic [52:0] rin(input int i);
        logic [52:0] v = '0;
        v[16+i] = 1'b1;
        return v;
    endfunction

    function automatic logic [52:0] rout(input int i);
        logic [52:0] v = '0;
        v[32+i] = 1'b1;
        return v;
    endfunction

    function automatic logic [52:0] alu(input logic [4:0] op);
        logic [52:0] v = '0;
        v[52:48] = op;
        return v;
    endfunction

    function automatic void chk(input string nm, input logic [52:0] a, input logic [52:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at t=%0t actual=%h required=%h", nm, $time, a, e);
        end
    endfunction

    // Whole-instruction expected strobe list, built from the opcode's class.
    task automatic start_instr();
        logic [4:0] op;
        int  ra, rb, rc;
        bit  md, un, legal;
        cur_ir = pending_ir;
        op = cur_ir[31:27];
        ra = int'(cur_ir[26:23]);
        rb = int'(cur_ir[22:19]);
        rc = int'(cur_ir[18:15]);
        md = (op == 5'b01111) || (op == 5'b10000);
        un = (op == 5'b10001) || (op == 5'b10010);
        legal = md || un || (op >= 5'd3 && op <= 5'd11);
        q.delete();
        q.push_back('{F_PCOUT | F_MARIN | F_INCPC | F_ZIN, 1'b0, 1'b0, 1'b0});
        q.push_back('{F_ZLOOUT | F_PCIN | F_READ | F_MDRIN, 1'b0, 1'b0, 1'b0});
        q.push_back('{F_MDROUT | F_IRIN, 1'b0, 1'b0, 1'b0});
        if (!legal) begin
            q.push_back('{53'd0, 1'b1, 1'b0, 1'b1});
        end else begin
            q.push_back('{F_YIN | rout(md ? ra : rb), 1'b1, 1'b0, 1'b0});
            q.push_back('{F_ZIN | alu(op) | rout((md || un) ? rb : rc), 1'b1, 1'b0, 1'b0});
            if (md) begin
                q.push_back('{F_ZLOOUT | F_LOIN, 1'b1, 1'b0, 1'b0});
                q.push_back('{F_ZHIOUT | F_HIIN | F_DONE, 1'b1, 1'b1, 1'b0});
            end else begin
                q.push_back('{F_ZLOOUT | rin(ra) | F_DONE, 1'b1, 1'b1, 1'b0});
            end
        end
        mode = M_RUN;
    endtask

    task automatic step(input bit rstn, input bit run);
        step_t s;
        @(posedge Clock);
        cyc++;
        if (!rst_s) begin
            mode = M_IDLE;
            q.delete();
        end else if (mode == M_IDLE) begin
            if (run_s) start_instr();
        end else if (mode == M_RUN && q.size() > 0) begin
            s = q.pop_front();
            if (s.halt) mode = M_HALT;
            else if (s.last) begin
                if (run_s) start_instr();
                else mode = M_IDLE;
            end
        end
        #1;
        Resetn = rstn;
        Run    = run;
        IR     = (mode == M_RUN && q.size() > 0 && q[0].drive_ir) ? cur_ir : $urandom();
        #1;
        if (mode == M_IDLE)      expv = '0;
        else if (mode == M_HALT) expv = F_ILL;
        else                     expv = (q.size() > 0) ? q[0].v : '1;
        act = {ALUControl, Rout, Rin, Illegal, Done, Read, LOin, HIin, Zin, Yin, IRin,
               MDRin, MARin, IncrementPC, PCin, MDRout, ZLOout, ZHIout, PCout};
        chk("cycle_vec", act, expv);
        rst_s = rstn;
        run_s = run;
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  op;

        pending_ir = 32'h28918000;
        step(0, 1);
        step(0, 1);
        chk("reset_idle", act, 53'd0);
        step(1, 1);
        step(1, 1);
        chk("t0_strobes", act, F_PCOUT | F_MARIN | F_INCPC | F_ZIN);
        t0_cyc = cyc;
        step(1, 1);
        step(1, 1);
        step(1, 1);
        chk("and_t3", act, F_YIN | (53'h0004 << 32));
        step(1, 1);
        chk("and_t4", act, F_ZIN | (53'h0008 << 32) | (53'h05 << 48));
        pending_ir = 32'h83380000;
        step(1, 1);
        chk("and_t5", act, F_ZLOOUT | F_DONE | (53'h0002 << 16));
        step(1, 1);
        chk("and_latency", 53'(cyc - t0_cyc), 53'd6);
        t0_cyc = cyc;
        step(1, 1);
        step(1, 1);
        step(1, 1);
        chk("div_t3", act, F_YIN | (53'h0040 << 32));
        step(1, 1);
        chk("div_t4", act, F_ZIN | (53'h0080 << 32) | (53'h10 << 48));
        step(1, 1);
        chk("div_t5", act, F_ZLOOUT | F_LOIN);
        pending_ir = 32'h18918000;
        step(1, 1);
        chk("div_t6", act, F_ZHIOUT | F_HIIN | F_DONE);
        step(1, 1);
        chk("div_latency", 53'(cyc - t0_cyc), 53'd7);
        step(1, 1);
        step(1, 1);
        step(1, 0);
        step(1, 0);
        step(1, 0);
        chk("add_done_after_drop", act, F_ZLOOUT | F_DONE | (53'h0002 << 16));
        step(1, 0);
        chk("idle_after_drop", act, 53'd0);
        step(1, 0);
        chk("no_read_idle", 53'(Read), 53'd0);

        pending_ir = 32'hF8000000;
        step(1, 1);
        for (int i = 0; i < 4; i++) step(1, 1);
        chk("illegal_t3", act, 53'd0);
        for (int i = 0; i < 5; i++) step(1, 1);
        chk("halt_sticky", act, F_ILL);
        step(0, 1);
        step(1, 0);
        chk("illegal_cleared", 53'(Illegal), 53'd0);

        pending_ir = 32'h7A280000;
        step(1, 1);
        for (int i = 0; i < 4; i++) step(1, 1);
        step(0, 0);
        chk("mul_t4", act, F_ZIN | (53'h0020 << 32) | (53'h0F << 48));
        step(1, 0);
        chk("mul_reset_idle", act, 53'd0);
        step(1, 0);
        chk("mul_no_lohi", 53'({LOin, HIin}), 53'd0);

        for (int n = 0; n < 4000; n++) begin
            r  = $urandom();
            op = ($urandom_range(0, 11) == 0) ? 5'($urandom()) : legal_ops[$urandom_range(0, 12)];
            pending_ir = {op, r[26:0]};
            step($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
